// File: rtl/io_sw_char_driver.sv
// io_sw_char_driver: transmit side of the GPIO character channel.
// Bytes pushed by the host are queued in a small FIFO. Each byte is presented on o_io_sw[7:0]
// with a request toggle on o_io_sw[8]. The core acknowledges the byte by copying that toggle
// onto i_io_ledr[ACK_BIT].
// Optional feature: define IO_SW_DRV_TIMEOUT_EN to add a WAIT_ACK watchdog. When the watchdog
// expires the block enters a sticky ERR state and raises o_timeout.
module io_sw_char_driver #(
  parameter int FIFO_DEPTH     = 16,
  parameter int ACK_BIT        = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_vld,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_rdy,
  input  logic [31:0] i_io_ledr,
  output logic [31:0] o_io_sw,
  output logic        o_busy,
  output logic [15:0] o_sent_cnt,
  output logic        o_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
`ifdef IO_SW_DRV_TIMEOUT_EN
    ST_WAIT_ACK,
    ST_ERR
`else
    ST_WAIT_ACK
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic [7:0]      data_q, data_d;
  logic            tog_q, tog_d;
  logic            pending_q, pending_d;
  logic            busy_q, busy_d;
  logic [15:0]     sent_cnt_q, sent_cnt_d;
  logic            push;
  logic            pop;
  logic            ack_seen;
  logic            unused_ledr;

  // Only one LEDR bit is the acknowledge; the remaining bits are deliberately ignored.
  assign unused_ledr = ^i_io_ledr;

`ifdef IO_SW_DRV_TIMEOUT_EN
  logic [16:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic        unused_timeout;
  // The watchdog limit only matters in builds that include the watchdog.
  assign unused_timeout = ^TIMEOUT_LIMIT;
`endif

  // A full FIFO refuses a push even if a pop happens in the same cycle. Pops happen only in SEND.
  assign push     = i_wr_vld & ~full_q;
  assign pop      = (state_q == ST_SEND);
  assign ack_seen = (i_io_ledr[ACK_BIT] == tog_q);

  // Update the FIFO pointers and the occupancy count, and precompute the next full and empty flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Handshake sequencing: pick up a byte, present it with a fresh toggle, then wait for the mirror.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tog_d      = tog_q;
    sent_cnt_d = sent_cnt_q;
`ifdef IO_SW_DRV_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) state_d = ST_SEND;
      end
      ST_SEND: begin
        data_d  = mem_q[rd_ptr_q];
        tog_d   = ~tog_q;
        state_d = ST_WAIT_ACK;
`ifdef IO_SW_DRV_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT_ACK: begin
        if (ack_seen) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          state_d    = ST_IDLE;
        end
`ifdef IO_SW_DRV_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_cnt_q + 17'd1;
          if (wait_cnt_d == TIMEOUT_LIMIT) state_d = ST_ERR;
        end
`endif
      end
      default: begin
        state_d = state_q;
      end
    endcase
    pending_d = (state_d == ST_WAIT_ACK) || (count_d != '0);
    busy_d    = (state_d != ST_IDLE) || (count_d != '0);
`ifdef IO_SW_DRV_TIMEOUT_EN
    timeout_d = timeout_q | (state_d == ST_ERR);
`endif
  end

  // Byte storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  // Register all control state and outputs. Reset discards queued bytes and any byte in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      data_q     <= 8'h00;
      tog_q      <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      sent_cnt_q <= 16'h0000;
`ifdef IO_SW_DRV_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      data_q     <= data_d;
      tog_q      <= tog_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      sent_cnt_q <= sent_cnt_d;
`ifdef IO_SW_DRV_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign o_wr_rdy   = ~full_q;
  assign o_io_sw    = {22'b0, pending_q, tog_q, data_q};
  assign o_busy     = busy_q;
  assign o_sent_cnt = sent_cnt_q;
`ifdef IO_SW_DRV_TIMEOUT_EN
  assign o_timeout  = timeout_q;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_io_sw_char_driver.sv
// Testbench for io_sw_char_driver.
// The bench models the channel as an ordered byte queue. It counts occupancy from the pushes it
// makes and the bytes it sees presented, and it acts as a responder that mirrors the toggle.
`timescale 1ns/1ps
module tb_io_sw_char_driver;

  localparam int FIFO_DEPTH     = 16;
  localparam int ACK_BIT        = 8;
  localparam int TIMEOUT_CYCLES = 20;

  logic        i_clk     = 1'b0;
  logic        i_reset   = 1'b1;
  logic        i_wr_vld  = 1'b0;
  logic [7:0]  i_wr_data = 8'h00;
  logic        o_wr_rdy;
  logic [31:0] i_io_ledr = 32'h0;
  logic [31:0] o_io_sw;
  logic        o_busy;
  logic [15:0] o_sent_cnt;
  logic        o_timeout;

  io_sw_char_driver #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ACK_BIT(ACK_BIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_wr_vld(i_wr_vld),
    .i_wr_data(i_wr_data),
    .o_wr_rdy(o_wr_rdy),
    .i_io_ledr(i_io_ledr),
    .o_io_sw(o_io_sw),
    .o_busy(o_busy),
    .o_sent_cnt(o_sent_cnt),
    .o_timeout(o_timeout)
  );

  // Free-running 100 MHz clock
  always #5 i_clk = ~i_clk;

  int         n_checks   = 0;
  int         n_fail     = 0;
  logic [7:0] exp_q[$];
  int         model_occ  = 0;
  int         model_sent = 0;
  logic       exp_tog    = 1'b0;
  logic       prev_tog   = 1'b0;
  bit         ack_en     = 1'b0;
  int         ack_delay  = 0;
  bit         outstanding = 1'b0;
  int         ack_wait   = 0;
  bit         ack_chk    = 1'b0;

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard and responder. This process watches the toggle to see each byte as it is presented,
  // and it mirrors the toggle back once ack_delay cycles have passed.
  always begin : monitor
    logic [7:0] e;
    @(posedge i_clk);
    #2;
    if (i_reset === 1'b1) begin
      prev_tog    = 1'b0;
      exp_tog     = 1'b0;
      outstanding = 1'b0;
      ack_chk     = 1'b0;
      ack_wait    = 0;
      model_sent  = 0;
      model_occ   = 0;
      exp_q.delete();
      i_io_ledr   = 32'h0;
    end else if (i_reset === 1'b0) begin
      if (ack_chk) begin
        ack_chk = 1'b0;
        model_sent++;
        check_output("sent_cnt", 32'(o_sent_cnt), 32'(16'(model_sent)));
        check_output("pending_after_ack", 32'(o_io_sw[9]), 32'(model_occ != 0));
      end
      if (o_io_sw[8] !== prev_tog) begin
        prev_tog = o_io_sw[8];
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none at %0t", o_io_sw[7:0], $time);
        end else begin
          e = exp_q.pop_front();
          model_occ--;
          exp_tog = ~exp_tog;
          check_output("byte", 32'(o_io_sw[7:0]), 32'(e));
          check_output("toggle", 32'(o_io_sw[8]), 32'(exp_tog));
          check_output("pending_in_wait", 32'(o_io_sw[9]), 32'h1);
          check_output("sw_upper_zero", 32'(o_io_sw[31:10]), 32'h0);
          outstanding = 1'b1;
          ack_wait    = 0;
        end
      end
      if (outstanding && ack_en) begin
        if (ack_wait >= ack_delay) begin
          i_io_ledr[ACK_BIT] = exp_tog;
          outstanding = 1'b0;
          ack_chk     = 1'b1;
        end else begin
          ack_wait++;
        end
      end
    end
  end

  // Offer one byte. The bench decides acceptance from its own occupancy count.
  task automatic apply_stimulus(input logic [7:0] b, output bit acc);
    bit exp_rdy;
    @(negedge i_clk);
    i_wr_vld  = 1'b1;
    i_wr_data = b;
    exp_rdy   = (model_occ < FIFO_DEPTH);
    check_output("wr_rdy", 32'(o_wr_rdy), 32'(exp_rdy));
    @(posedge i_clk);
    acc = exp_rdy;
    if (acc) begin
      exp_q.push_back(b);
      model_occ++;
    end
    #1;
    i_wr_vld = 1'b0;
  endtask

  // Hold reset for a number of cycles with a push request active.
  task automatic do_reset(input int cycles);
    @(negedge i_clk);
    i_reset   = 1'b1;
    i_wr_vld  = 1'b1;
    i_wr_data = 8'hAA;
    repeat (cycles) @(negedge i_clk);
    i_reset  = 1'b0;
    i_wr_vld = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_io_sw"}, o_io_sw, 32'h0);
    check_output({tag, "_sent_cnt"}, 32'(o_sent_cnt), 32'h0);
    check_output({tag, "_wr_rdy"}, 32'(o_wr_rdy), 32'h1);
    check_output({tag, "_busy"}, 32'(o_busy), 32'h0);
    check_output({tag, "_timeout"}, 32'(o_timeout), 32'h0);
  endtask

  // Wait until every expected byte has been presented and acknowledged, with a cycle budget.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding || ack_chk) && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d bytes left, expected 0 within %0d cycles", exp_q.size(), budget);
    end
    repeat (2) @(negedge i_clk);
    check_output("busy_idle", 32'(o_busy), 32'h0);
    check_output("pending_idle", 32'(o_io_sw[9]), 32'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    bit acc;
    logic [7:0] hello [5];
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    // T1: reset held 3 cycles while a push is requested
    do_reset(3);
    check_reset_values("t1");
    repeat (3) @(negedge i_clk);
    check_output("t1_still_empty_busy", 32'(o_busy), 32'h0);
    check_output("t1_still_empty_sw", o_io_sw, 32'h0);

    // T2: single byte with exact presentation latency
    do_reset(2);
    ack_en = 1'b1;
    ack_delay = 2;
    apply_stimulus(8'h41, acc);
    @(posedge i_clk);
    #1;
    check_output("t2_e1_sw", o_io_sw, 32'h200);
    @(posedge i_clk);
    #1;
    check_output("t2_e2_sw", o_io_sw, 32'h341);
    wait_drain(50);
    check_output("t2_after_ack_sw", o_io_sw, 32'h141);
    check_output("t2_sent_cnt", 32'(o_sent_cnt), 32'h1);

    // T3: "HELLO" back-to-back, ack about 3 cycles after each toggle
    do_reset(2);
    ack_en = 1'b1;
    ack_delay = 2;
    for (int i = 0; i < 5; i++) apply_stimulus(hello[i], acc);
    wait_drain(200);
    check_output("t3_sent_cnt", 32'(o_sent_cnt), 32'h5);
    check_output("t3_last_sw", o_io_sw, 32'h14F);

    // T4: 17 bytes fit (one is popped), the 18th is refused
    do_reset(2);
    ack_en = 1'b0;
    for (int i = 0; i <= 16; i++) apply_stimulus(8'(i), acc);
    apply_stimulus(8'h11, acc);
    check_output("t4_reject_accepted", 32'(acc), 32'h0);
    ack_delay = 0;
    ack_en = 1'b1;
    wait_drain(400);
    check_output("t4_sent_cnt", 32'(o_sent_cnt), 32'd17);
    check_output("t4_timeout_zero", 32'(o_timeout), 32'h0);

    // T5: reset while waiting for an ack, with 4 bytes still queued
    do_reset(2);
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(8'hA0 + 8'(i), acc);
    repeat (4) @(negedge i_clk);
    check_output("t5_busy_before", 32'(o_busy), 32'h1);
    do_reset(2);
    check_reset_values("t5");
    ack_en = 1'b1;
    repeat (30) @(negedge i_clk);
    check_output("t5_no_send_sw", o_io_sw, 32'h0);
    check_output("t5_no_send_cnt", 32'(o_sent_cnt), 32'h0);

    // Randomized traffic with random gaps and random ack delays
    do_reset(2);
    ack_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(0, 4);
      apply_stimulus(8'($urandom), acc);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    wait_drain(1000);
    check_output("rand_sent_cnt", 32'(o_sent_cnt), 32'(16'(model_sent)));

`ifdef IO_SW_DRV_TIMEOUT_EN
    // T6: watchdog expires after TIMEOUT_CYCLES cycles in WAIT_ACK
    do_reset(2);
    ack_en = 1'b0;
    apply_stimulus(8'h55, acc);
    repeat (TIMEOUT_CYCLES + 1) @(posedge i_clk);
    #1;
    check_output("t6_timeout_early", 32'(o_timeout), 32'h0);
    @(posedge i_clk);
    #1;
    check_output("t6_timeout_set", 32'(o_timeout), 32'h1);
    apply_stimulus(8'hA1, acc);
    apply_stimulus(8'hA2, acc);
    repeat (10) @(negedge i_clk);
    check_output("t6_sw_frozen", o_io_sw, 32'h355);
    check_output("t6_timeout_sticky", 32'(o_timeout), 32'h1);
    check_output("t6_busy", 32'(o_busy), 32'h1);
    do_reset(2);
    check_reset_values("t6");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
